// File: rtl/systolic_tile_sequencer.sv
// Control sequencer for one systolic tile: weight burst, gap, ifmap stream,
// then psum capture strobes, with abort and start validation.
module systolic_tile_sequencer #(
  parameter int ARRAY_DIM = 16,
  parameter int CNT_W     = 10,
  parameter int PSUM_LAT  = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_W-1:0]             num_ifmap,
  input  logic                         abort,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic                         w_enable_out,
  output logic [$clog2(ARRAY_DIM)-1:0] w_addr,
  output logic                         ifmap_enable_out,
  output logic [CNT_W-1:0]             ifmap_addr,
  output logic                         psum_capture,
  output logic [CNT_W-1:0]             psum_addr
);

  localparam int AW = $clog2(ARRAY_DIM);
  localparam int LW = $clog2(PSUM_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, GAP, STREAM, DRAIN, DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] n_q;
  logic [LW-1:0]    lat;
  logic             lat_on;
  logic             size_ok;
  logic             kill;
  logic             last_cap;

  assign size_ok  = num_ifmap >= CNT_W'(ARRAY_DIM);
  assign kill     = abort && (state != IDLE);
  assign last_cap = psum_capture && (psum_addr == n_q - 1'b1);

  always_comb begin
    state_n = state;
    if (kill) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:   if (start && !abort && size_ok) state_n = LOAD_W;
        LOAD_W: if (w_addr == AW'(ARRAY_DIM - 1)) state_n = GAP;
        GAP:    state_n = STREAM;
        STREAM: if (ifmap_addr == n_q - 1'b1) state_n = DRAIN;
        DRAIN:  if (last_cap) state_n = DONE;
        DONE:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      n_q              <= '0;
      ready            <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
      w_enable_out     <= 1'b0;
      w_addr           <= '0;
      ifmap_enable_out <= 1'b0;
      ifmap_addr       <= '0;
      psum_capture     <= 1'b0;
      psum_addr        <= '0;
      lat              <= '0;
      lat_on           <= 1'b0;
    end else begin
      state            <= state_n;
      ready            <= state_n == IDLE;
      busy             <= state_n != IDLE;
      done             <= state_n == DONE;
      cfg_err          <= (state == IDLE) && start && !abort && !size_ok;
      w_enable_out     <= state_n == LOAD_W;
      ifmap_enable_out <= state_n == STREAM;
      if (state == IDLE && state_n == LOAD_W) n_q <= num_ifmap;
      if (state_n == LOAD_W && state == LOAD_W) w_addr <= w_addr + 1'b1;
      else w_addr <= '0;
      if (state_n == STREAM && state == STREAM) ifmap_addr <= ifmap_addr + 1'b1;
      else ifmap_addr <= '0;
      if (kill) begin
        lat          <= '0;
        lat_on       <= 1'b0;
        psum_capture <= 1'b0;
        psum_addr    <= '0;
      end else begin
        if (psum_capture) begin
          if (last_cap) begin
            psum_capture <= 1'b0;
            psum_addr    <= '0;
          end else begin
            psum_addr <= psum_addr + 1'b1;
          end
        end
        // Latency timer starts on the first stream cycle.
        if (state == GAP && state_n == STREAM) begin
          lat_on <= 1'b1;
          lat    <= '0;
        end else if (lat_on) begin
          if (lat == LW'(PSUM_LAT - 1)) begin
            lat_on       <= 1'b0;
            lat          <= '0;
            psum_capture <= 1'b1;
            psum_addr    <= '0;
          end else begin
            lat <= lat + 1'b1;
          end
        end
      end
    end
  end

endmodule
